// File: rtl/mem_map_pkg.sv
// Memory-stage address map and port-B arbiter shared types.
package mem_map_pkg;

  localparam logic [31:0] IMAGE_END = 32'd89999;
  localparam logic [31:0] SIN_BASE  = IMAGE_END + 32'd1;
  localparam logic [31:0] SIN_END   = 32'd90299;
  localparam logic [31:0] RAM_BASE  = SIN_END + 32'd1;

  typedef enum logic {IDLE, BURST} arb_state_t;

  typedef struct packed {
    logic id;
    logic err;
    logic last;
  } beat_sb_t;

  function automatic logic addr_illegal(
    input logic [31:0] a,
    input logic [31:0] top
  );
    return ((a >= SIN_BASE) && (a <= SIN_END)) || (a > top);
  endfunction

endpackage

// File: rtl/port_b_reader_arbiter_rsp_pipe.sv
// Fixed-latency shift register carrying beat sideband alongside
// the port-B read data.
module rsp_pipe
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  beat_sb_t in_sb,
  output logic     out_valid,
  output beat_sb_t out_sb
);

  logic     [DEPTH-1:0] vld_q, vld_d;
  beat_sb_t [DEPTH-1:0] sb_q, sb_d;

  always_comb begin
    vld_d    = vld_q;
    sb_d     = sb_q;
    vld_d[0] = in_valid;
    sb_d[0]  = in_sb;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      sb_d[i]  = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      sb_q  <= '0;
    end else begin
      vld_q <= vld_d;
      sb_q  <= sb_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_sb    = sb_q[DEPTH-1];

endmodule

// File: rtl/port_b_reader_arbiter.sv
// Round-robin burst arbiter sharing read-only port B between
// video scan-out (id 0) and debug dump (id 1).
module port_b_reader_arbiter
  import mem_map_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned RAM_TOP = RAM_BASE + 32'd131071
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last
);

  arb_state_t        state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] hold_q, hold_d;

  logic              gnt0, gnt1;
  logic              beat_err, beat_last;
  logic [ADDR_W-1:0] beat_addr;
  logic              push;
  beat_sb_t          push_sb, pop_sb;
  logic              pop_valid;

  assign gnt0 = req0_valid && (!req1_valid || !rr_q);
  assign gnt1 = req1_valid && (!req0_valid || rr_q);

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;

  assign beat_err  = addr_illegal(32'(cur_addr_q), 32'(RAM_TOP));
  assign beat_last = (beats_q == '0);
  assign beat_addr = beat_err ? '0 : cur_addr_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    beats_d    = beats_q;
    cur_addr_d = cur_addr_q;
    hold_d     = hold_q;
    push       = 1'b0;
    push_sb    = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          cur_addr_d = gnt1 ? req1_addr : req0_addr;
          beats_d    = gnt1 ? req1_len : req0_len;
          owner_d    = gnt1;
          rr_d       = !gnt1;
          state_d    = BURST;
        end
      end
      BURST: begin
        push         = 1'b1;
        push_sb.id   = owner_q;
        push_sb.err  = beat_err;
        push_sb.last = beat_last;
        hold_d       = beat_addr;
        cur_addr_d   = cur_addr_q + ADDR_W'(1);
        if (beat_last) begin
          state_d = IDLE;
        end else begin
          beats_d = beats_q - LEN_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      beats_q    <= '0;
      cur_addr_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      beats_q    <= beats_d;
      cur_addr_q <= cur_addr_d;
      hold_q     <= hold_d;
    end
  end

  // Address is live during BURST; IDLE parks on the last issued beat
  assign mem_addr = (state_q == BURST) ? beat_addr : hold_q;

  rsp_pipe #(
    .DEPTH(LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push),
    .in_sb    (push_sb),
    .out_valid(pop_valid),
    .out_sb   (pop_sb)
  );

  assign rsp_valid = pop_valid;
  assign rsp_id    = pop_valid && pop_sb.id;
  assign rsp_err   = pop_valid && pop_sb.err;
  assign rsp_last  = pop_valid && pop_sb.last;
  assign rsp_data  = (pop_valid && !pop_sb.err) ? mem_rdata : '0;

endmodule
